// File: rtl/hdmi_fetch_pkg.sv
// hdmi_fetch_pkg: shared types and constants for the HDMI frame fetch scheduler.
//   state_t      fetch FSM states
//   BOUNDARY_4K  AXI bursts must not cross this byte boundary
//   bpb_of / bpb_log2_of / credit_width  derive widths from module parameters
package hdmi_fetch_pkg;
    typedef enum logic [1:0] {IDLE, WAIT_FRAME, ISSUE, DRAIN} state_t;
    localparam int BOUNDARY_4K = 4096;
    function automatic int bpb_of(input int data_width);
        return data_width / 8;
    endfunction
    function automatic int bpb_log2_of(input int data_width);
        return $clog2(data_width / 8);
    endfunction
    function automatic int credit_width(input int fifo_depth);
        return $clog2(fifo_depth + 1);
    endfunction
endpackage

// File: rtl/hdmi_fetch_burst_calc.sv
// hdmi_fetch_burst_calc: combinational burst length for the next AR request.
//   addr_low    low 12 bits of the current byte address (BPB-aligned)
//   beats_left  beats remaining in the current line (1..4095)
//   len         beats in the next burst: min(beats_left, BURST_LEN, beats to 4 KB edge)
module hdmi_fetch_burst_calc
    import hdmi_fetch_pkg::*;
#(
    parameter int BURST_LEN = 16,
    parameter int BPB_LOG2  = 6
)(
    input  logic [11:0] addr_low,
    input  logic [11:0] beats_left,
    output logic [8:0]  len
);
    logic [12:0] room;
    logic [12:0] cap;
    always_comb begin
        room = (13'(BOUNDARY_4K) - {1'b0, addr_low}) >> BPB_LOG2;
        cap  = room < 13'(BURST_LEN) ? room : 13'(BURST_LEN);
        len  = 9'({1'b0, beats_left} < cap ? {1'b0, beats_left} : cap);
    end
endmodule

// File: rtl/hdmi_frame_fetch.sv
// hdmi_frame_fetch: schedules line-by-line AXI read bursts for one video frame per FRAME_START.
//   ACLK/nRST       clock, asynchronous active-low reset
//   CFG_*           frame geometry, latched when a frame starts
//   FRAME_START     VSYNC pulse; FIFO_POP frees one line FIFO credit
//   M_AR*/M_R*      AXI read address issue and read beat counting (data bypasses this block)
//   FIFO_PUSH       line FIFO write strobe; BUSY/FRAME_DONE/OVERRUN/ERR_RESP status
module hdmi_frame_fetch
    import hdmi_fetch_pkg::*;
#(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 512,
    parameter int C_BURST_LEN        = 16,
    parameter int C_FIFO_DEPTH       = 256,
    parameter int C_MAX_OUTSTANDING  = 4
)(
    input  logic                          ACLK,
    input  logic                          nRST,
    input  logic                          CFG_ENABLE,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] CFG_BASE_ADDR,
    input  logic [11:0]                   CFG_LINE_BEATS,
    input  logic [11:0]                   CFG_HEIGHT,
    input  logic [15:0]                   CFG_STRIDE,
    input  logic                          FRAME_START,
    input  logic                          FIFO_POP,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] M_ARADDR,
    output logic [7:0]                    M_ARLEN,
    output logic                          M_ARVALID,
    input  logic                          M_ARREADY,
    input  logic                          M_RVALID,
    input  logic                          M_RLAST,
    input  logic [1:0]                    M_RRESP,
    output logic                          M_RREADY,
    output logic                          FIFO_PUSH,
    output logic                          BUSY,
    output logic                          FRAME_DONE,
    output logic                          OVERRUN,
    output logic                          ERR_RESP
);
    localparam int AW       = C_M_AXI_ADDR_WIDTH;
    localparam int BPB_LOG2 = bpb_log2_of(C_M_AXI_DATA_WIDTH);
    localparam int CW       = credit_width(C_FIFO_DEPTH);
    localparam int OW       = $clog2(C_MAX_OUTSTANDING + 1);

    state_t        state, state_nxt;
    logic [AW-1:0] line_addr, cur_addr;
    logic [15:0]   stride_q;
    logic [11:0]   line_beats_q, height_q, line, beats_left;
    logic [CW-1:0] credits;
    logic [OW-1:0] outstanding;
    logic [8:0]    len;
    logic          aborted, latch, ar_hs, r_hs, line_end, last_burst, drained, issue, pop_ok;

    hdmi_fetch_burst_calc #(.BURST_LEN(C_BURST_LEN), .BPB_LOG2(BPB_LOG2)) u_calc (
        .addr_low   (cur_addr[11:0]),
        .beats_left (beats_left),
        .len        (len)
    );

    // Credits reserve FIFO space at AR time, so read data can always be accepted.
    assign M_RREADY   = 1'b1;
    assign FIFO_PUSH  = M_RVALID & M_RREADY;
    assign BUSY       = state == ISSUE || state == DRAIN;
    assign ar_hs      = M_ARVALID & M_ARREADY;
    assign r_hs       = M_RVALID & M_RREADY;
    assign line_end   = beats_left == 12'(len);
    assign last_burst = line_end && line == height_q - 12'd1;
    assign drained    = outstanding == '0 && !r_hs;
    assign pop_ok     = FIFO_POP && credits != CW'(C_FIFO_DEPTH);
    assign issue      = state == ISSUE && CFG_ENABLE && !M_ARVALID &&
                        32'(credits) >= 32'(len) && outstanding < OW'(C_MAX_OUTSTANDING);

    always_ff @(posedge ACLK or negedge nRST) begin
        if (!nRST) state <= IDLE;
        else       state <= state_nxt;
    end

    // A pending AR may still complete after disable; the FSM leaves ISSUE once none is in flight.
    always_comb begin
        state_nxt = state;
        latch     = 1'b0;
        case (state)
            IDLE:       state_nxt = CFG_ENABLE ? WAIT_FRAME : IDLE;
            WAIT_FRAME: begin
                latch     = CFG_ENABLE && FRAME_START;
                state_nxt = !CFG_ENABLE ? IDLE : FRAME_START ? ISSUE : WAIT_FRAME;
            end
            ISSUE:      state_nxt = (ar_hs && last_burst) || (!CFG_ENABLE && (!M_ARVALID || M_ARREADY)) ? DRAIN : ISSUE;
            DRAIN:      state_nxt = !drained ? DRAIN : aborted ? IDLE : WAIT_FRAME;
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge nRST) begin
        if (!nRST) begin
            M_ARVALID    <= 1'b0;
            M_ARADDR     <= '0;
            M_ARLEN      <= '0;
            FRAME_DONE   <= 1'b0;
            OVERRUN      <= 1'b0;
            ERR_RESP     <= 1'b0;
            credits      <= CW'(C_FIFO_DEPTH);
            outstanding  <= '0;
            aborted      <= 1'b0;
            line_addr    <= '0;
            cur_addr     <= '0;
            stride_q     <= '0;
            line_beats_q <= '0;
            height_q     <= '0;
            line         <= '0;
            beats_left   <= '0;
        end else begin
            FRAME_DONE  <= state == DRAIN && drained && !aborted;
            OVERRUN     <= FRAME_START && BUSY;
            ERR_RESP    <= (ERR_RESP && !latch) || (r_hs && M_RRESP != 2'b00);
            credits     <= credits - (ar_hs ? CW'(len) : '0) + CW'(pop_ok);
            outstanding <= outstanding + OW'(ar_hs) - OW'(r_hs && M_RLAST);
            aborted     <= !latch && (aborted || (state == ISSUE && !CFG_ENABLE));
            if (issue) begin
                M_ARVALID <= 1'b1;
                M_ARADDR  <= cur_addr;
                M_ARLEN   <= 8'(len - 9'd1);
            end else if (ar_hs) begin
                M_ARVALID <= 1'b0;
            end
            if (latch) begin
                line_addr    <= CFG_BASE_ADDR;
                cur_addr     <= CFG_BASE_ADDR;
                stride_q     <= CFG_STRIDE;
                line_beats_q <= CFG_LINE_BEATS;
                height_q     <= CFG_HEIGHT;
                line         <= '0;
                beats_left   <= CFG_LINE_BEATS;
            end else if (ar_hs && line_end) begin
                line_addr  <= line_addr + AW'(stride_q);
                cur_addr   <= line_addr + AW'(stride_q);
                line       <= line + 12'd1;
                beats_left <= line_beats_q;
            end else if (ar_hs) begin
                cur_addr   <= cur_addr + (AW'(len) << BPB_LOG2);
                beats_left <= beats_left - 12'(len);
            end
        end
    end

    // Popping a FIFO that holds no reserved beats is a consumer bug; credits saturate regardless.
    a_pop_when_full: assert property (@(posedge ACLK) disable iff (!nRST)
        !(FIFO_POP && credits == CW'(C_FIFO_DEPTH)));
endmodule

// File: tb/tb_hdmi_frame_fetch.sv
// tb_hdmi_frame_fetch: directed frames with an AR scoreboard, a responding AXI slave and a FIFO consumer.
module tb_hdmi_frame_fetch;
    localparam int DEPTH = 32;
    localparam int BIG   = 1000000;

    logic        ACLK = 1'b0;
    logic        nRST = 1'b0;
    logic        CFG_ENABLE = 1'b0;
    logic [31:0] CFG_BASE_ADDR = '0;
    logic [11:0] CFG_LINE_BEATS = '0;
    logic [11:0] CFG_HEIGHT = '0;
    logic [15:0] CFG_STRIDE = '0;
    logic        FRAME_START = 1'b0;
    logic        FIFO_POP = 1'b0;
    logic [31:0] M_ARADDR;
    logic [7:0]  M_ARLEN;
    logic        M_ARVALID;
    logic        M_ARREADY = 1'b0;
    logic        M_RVALID = 1'b0;
    logic        M_RLAST = 1'b0;
    logic [1:0]  M_RRESP = 2'b00;
    logic        M_RREADY;
    logic        FIFO_PUSH;
    logic        BUSY;
    logic        FRAME_DONE;
    logic        OVERRUN;
    logic        ERR_RESP;

    always #5 ACLK = ~ACLK;

    hdmi_frame_fetch #(.C_FIFO_DEPTH(DEPTH)) dut (
        .ACLK(ACLK), .nRST(nRST), .CFG_ENABLE(CFG_ENABLE), .CFG_BASE_ADDR(CFG_BASE_ADDR),
        .CFG_LINE_BEATS(CFG_LINE_BEATS), .CFG_HEIGHT(CFG_HEIGHT), .CFG_STRIDE(CFG_STRIDE),
        .FRAME_START(FRAME_START), .FIFO_POP(FIFO_POP), .M_ARADDR(M_ARADDR), .M_ARLEN(M_ARLEN),
        .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY), .M_RVALID(M_RVALID), .M_RLAST(M_RLAST),
        .M_RRESP(M_RRESP), .M_RREADY(M_RREADY), .FIFO_PUSH(FIFO_PUSH), .BUSY(BUSY),
        .FRAME_DONE(FRAME_DONE), .OVERRUN(OVERRUN), .ERR_RESP(ERR_RESP)
    );

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
    } ar_t;

    ar_t exp_q[$];
    int  rd_q[$];
    int  checks = 0, failures = 0;
    int  ar_count = 0, beat_count = 0, rlast_count = 0, done_count = 0, ovr_count = 0;
    int  lvl = 0, r_done = 0, cyc = 0;
    int  pop_budget = BIG, r_allow = BIG;
    bit  ar_mode = 1'b0, err_req = 1'b0;
    bit  prev_hs = 1'b0, prev_stall = 1'b0;
    logic [31:0] prev_addr;
    logic [7:0]  prev_len;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: samples at the falling edge what the next rising edge will commit.
    always @(negedge ACLK) begin
        ar_t e;
        if (nRST) begin
            if (prev_hs) chk("arvalid_gap", M_ARVALID, 0);
            if (prev_stall) begin
                chk("arvalid_hold", M_ARVALID, 1);
                chk("araddr_hold", M_ARADDR, prev_addr);
                chk("arlen_hold", M_ARLEN, prev_len);
            end
            if (M_ARVALID && M_ARREADY) begin
                ar_count++;
                chk("ar_4k", (int'(M_ARADDR[11:0]) + (int'(M_ARLEN) + 1) * 64) <= 4096, 1);
                if (exp_q.size() == 0) chk("ar_unexpected", M_ARADDR, 32'hFFFF_FFFF);
                else begin
                    e = exp_q.pop_front();
                    chk("araddr", M_ARADDR, e.addr);
                    chk("arlen", M_ARLEN, e.len);
                end
                rd_q.push_back(int'(M_ARLEN) + 1);
            end
            if (M_RVALID) begin
                beat_count++;
                lvl++;
                if (M_RLAST) rlast_count++;
                chk("fifo_push", FIFO_PUSH, 1);
            end
            if (FIFO_POP) lvl--;
            if (FRAME_DONE) done_count++;
            if (OVERRUN) ovr_count++;
            prev_hs    = M_ARVALID && M_ARREADY;
            prev_stall = M_ARVALID && !M_ARREADY;
            prev_addr  = M_ARADDR;
            prev_len   = M_ARLEN;
        end else begin
            prev_hs    = 1'b0;
            prev_stall = 1'b0;
        end
    end

    // AXI slave and FIFO consumer, driven just after each rising edge.
    always @(posedge ACLK) begin
        #1;
        cyc++;
        M_ARREADY = !ar_mode || (cyc % 3 == 0);
        if (!nRST) begin
            M_RVALID = 1'b0;
            M_RLAST  = 1'b0;
            M_RRESP  = 2'b00;
            FIFO_POP = 1'b0;
            r_done   = 0;
        end else begin
            FIFO_POP = pop_budget > 0 && lvl > 0;
            if (FIFO_POP) pop_budget--;
            if (M_RVALID) begin
                r_done++;
                if (r_done == rd_q[0]) begin
                    void'(rd_q.pop_front());
                    r_done = 0;
                    r_allow--;
                end
            end
            if (r_allow > 0 && rd_q.size() > 0) begin
                M_RVALID = 1'b1;
                M_RLAST  = r_done + 1 == rd_q[0];
                M_RRESP  = err_req ? 2'd2 : 2'd0;
                err_req  = 1'b0;
            end else begin
                M_RVALID = 1'b0;
                M_RLAST  = 1'b0;
                M_RRESP  = 2'b00;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge ACLK); #1; end
    endtask

    task automatic cfg(input logic [31:0] base, input int beats, input int height, input logic [15:0] stride);
        CFG_BASE_ADDR  = base;
        CFG_LINE_BEATS = 12'(beats);
        CFG_HEIGHT     = 12'(height);
        CFG_STRIDE     = stride;
    endtask

    task automatic push_ar(input logic [31:0] addr, input int len);
        ar_t e;
        e.addr = addr;
        e.len  = 8'(len);
        exp_q.push_back(e);
    endtask

    task automatic start_frame();
        @(posedge ACLK); #1;
        FRAME_START = 1'b1;
        @(posedge ACLK); #1;
        FRAME_START = 1'b0;
    endtask

    task automatic wait_ar(input int target, input int budget, input string name);
        for (int i = 0; i < budget && ar_count < target; i++) idle(1);
        chk(name, ar_count >= target, 1);
    endtask

    task automatic wait_done(input int target, input int budget, input string name);
        for (int i = 0; i < budget && done_count < target; i++) idle(1);
        chk(name, done_count >= target, 1);
    endtask

    task automatic wait_empty(input int budget);
        for (int i = 0; i < budget && lvl > 0; i++) idle(1);
        chk("fifo_drain", lvl, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, b0, d0, o0, rl0;
        idle(3);
        @(negedge ACLK);
        chk("rst_arvalid", M_ARVALID, 0);
        chk("rst_araddr", M_ARADDR, 0);
        chk("rst_arlen", M_ARLEN, 0);
        chk("rst_rready", M_RREADY, 1);
        chk("rst_busy", BUSY, 0);
        chk("rst_frame_done", FRAME_DONE, 0);
        chk("rst_overrun", OVERRUN, 0);
        chk("rst_err", ERR_RESP, 0);
        idle(1);
        nRST = 1'b1;

        // Line split: 40-beat lines become 16/16/8 bursts, with a stalling ARREADY.
        CFG_ENABLE = 1'b1;
        ar_mode = 1'b1;
        cfg(32'h1000, 40, 2, 16'h1000);
        push_ar(32'h1000, 15); push_ar(32'h1400, 15); push_ar(32'h1800, 7);
        push_ar(32'h2000, 15); push_ar(32'h2400, 15); push_ar(32'h2800, 7);
        b0 = beat_count; d0 = done_count;
        idle(3);
        start_frame();
        @(negedge ACLK);
        chk("t1_busy", BUSY, 1);
        wait_done(d0 + 1, 3000, "t1_done");
        chk("t1_beats", beat_count - b0, 80);
        chk("t1_ars_left", exp_q.size(), 0);
        idle(2);
        @(negedge ACLK);
        chk("t1_idle_busy", BUSY, 0);

        // 4 KB split.
        ar_mode = 1'b0;
        cfg(32'h0F80, 16, 1, 16'h1000);
        push_ar(32'h0F80, 1); push_ar(32'h1000, 13);
        b0 = beat_count; d0 = done_count;
        start_frame();
        wait_done(d0 + 1, 500, "t2_done");
        chk("t2_beats", beat_count - b0, 16);
        chk("t2_ars_left", exp_q.size(), 0);

        // Credit stall: no pops, 32-beat FIFO.
        wait_empty(200);
        pop_budget = 0;
        cfg(32'h0, 48, 1, 16'h1000);
        push_ar(32'h0, 15); push_ar(32'h400, 15); push_ar(32'h800, 15);
        a0 = ar_count; d0 = done_count;
        start_frame();
        idle(100);
        chk("t3_two_bursts", ar_count - a0, 2);
        @(negedge ACLK);
        chk("t3_arvalid_stall", M_ARVALID, 0);
        chk("t3_busy", BUSY, 1);
        pop_budget = 15;
        idle(60);
        chk("t3_still_two", ar_count - a0, 2);
        pop_budget = 1;
        wait_ar(a0 + 3, 50, "t3_third_after_16_pops");
        pop_budget = BIG;
        wait_done(d0 + 1, 500, "t3_done");

        // Outstanding limit: data held back.
        wait_empty(200);
        r_allow = 0;
        cfg(32'h0, 4, 8, 16'h100);
        for (int i = 0; i < 8; i++) push_ar(32'(i * 256), 3);
        a0 = ar_count; d0 = done_count; rl0 = rlast_count;
        start_frame();
        idle(60);
        chk("t4_four_out", ar_count - a0, 4);
        r_allow = 1;
        idle(40);
        chk("t4_one_rlast", rlast_count - rl0, 1);
        chk("t4_fifth", ar_count - a0, 5);
        r_allow = BIG;
        wait_done(d0 + 1, 1000, "t4_done");
        chk("t4_ars_left", exp_q.size(), 0);

        // Overrun and error response.
        wait_empty(200);
        ar_mode = 1'b1;
        cfg(32'h0, 32, 4, 16'h800);
        for (int i = 0; i < 4; i++) begin
            push_ar(32'(i * 32'h800), 15);
            push_ar(32'(i * 32'h800 + 32'h400), 15);
        end
        err_req = 1'b1;
        a0 = ar_count; b0 = beat_count; d0 = done_count; o0 = ovr_count;
        start_frame();
        wait_ar(a0 + 2, 200, "t5_in_issue");
        start_frame();
        idle(3);
        chk("t5_overrun_pulse", ovr_count - o0, 1);
        @(negedge ACLK);
        chk("t5_busy", BUSY, 1);
        wait_done(d0 + 1, 3000, "t5_done");
        chk("t5_beats", beat_count - b0, 128);
        chk("t5_err_sticky", ERR_RESP, 1);
        idle(20);
        chk("t5_one_frame", done_count - d0, 1);
        chk("t5_ars_left", exp_q.size(), 0);
        cfg(32'h0, 1, 1, 16'h1000);
        push_ar(32'h0, 0);
        d0 = done_count;
        start_frame();
        @(negedge ACLK);
        chk("t5_err_cleared", ERR_RESP, 0);
        wait_done(d0 + 1, 500, "t5b_done");

        // Disable mid-frame after 2 of 6 bursts.
        wait_empty(200);
        ar_mode = 1'b0;
        r_allow = 0;
        cfg(32'h0, 8, 6, 16'h400);
        push_ar(32'h0, 7); push_ar(32'h400, 7);
        a0 = ar_count; b0 = beat_count; d0 = done_count;
        start_frame();
        wait_ar(a0 + 2, 100, "t6_two_ars");
        CFG_ENABLE = 1'b0;
        idle(20);
        chk("t6_no_more_ar", ar_count - a0, 2);
        @(negedge ACLK);
        chk("t6_busy_held", BUSY, 1);
        chk("t6_arvalid", M_ARVALID, 0);
        r_allow = BIG;
        for (int i = 0; i < 200 && BUSY; i++) idle(1);
        @(negedge ACLK);
        chk("t6_busy_drop", BUSY, 0);
        chk("t6_beats", beat_count - b0, 16);
        idle(10);
        chk("t6_no_done", done_count - d0, 0);
        start_frame();
        idle(10);
        chk("t6_idle_ignores_start", ar_count - a0, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
